// File: rtl/picomem_wb_pkg.sv
// rtl/picomem_wb_pkg.sv - shared types and constants for the PicoMem to Wishbone bridge
package picomem_wb_pkg;

  // Bridge sequencing: wait for a request, run one Wishbone cycle, pulse ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word handed back to the CPU when a read ends in error or timeout
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picomem_wb_bridge_if.sv
// rtl/picomem_wb_bridge_if.sv - Wishbone B4 classic bus bundle with master/slave views
interface picomem_wb_bridge_if #(
  parameter int ADDR_WIDTH = 28
);

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [31:0]           wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  // Bridge side: drives the cycle, receives data and termination
  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  // Peripheral side: observes the cycle, returns data and termination
  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );

endinterface

// File: rtl/picomem_wb_bridge.sv
// rtl/picomem_wb_bridge.sv - one-at-a-time PicoMem slave to Wishbone classic master with watchdog
module picomem_wb_bridge
  import picomem_wb_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 28,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_s_valid,
  output logic                mem_s_ready,
  input  logic [31:0]         mem_s_addr,
  input  logic [31:0]         mem_s_wdata,
  input  logic [3:0]          mem_s_wstrb,
  output logic [31:0]         mem_s_rdata,
  picomem_wb_bridge_if.master wb,
  output logic                err_sticky,
  output logic [31:0]         err_addr,
  input  logic                err_clr
);

  // Counter must hold 0..TIMEOUT_CYCLES-1; keep at least one bit when the watchdog is off
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES > 0);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [31:0]           r_addr;
  logic                  r_cyc;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wb_adr;
  logic [31:0]           r_wb_dat;
  logic [3:0]            r_wb_sel;
  logic                  r_ready;
  logic [31:0]           r_rdata;
  logic                  r_err_sticky;
  logic [31:0]           r_err_addr;

  logic w_timeout;
  logic w_fail;
  logic w_bus_fail;

  // Watchdog fires on the last allowed wait cycle; ack in that same cycle still wins
  assign w_timeout  = WATCHDOG_ON && (r_cnt == CNT_LAST);
  assign w_fail     = wb.wb_err_i || (!wb.wb_ack_i && w_timeout);
  assign w_bus_fail = (r_state == BUS) && w_fail;

  assign mem_s_ready = r_ready;
  assign mem_s_rdata = r_rdata;
  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_wb_adr;
  assign wb.wb_dat_o = r_wb_dat;
  assign wb.wb_sel_o = r_wb_sel;
  assign err_sticky  = r_err_sticky;
  assign err_addr    = r_err_addr;

  // Transaction FSM: latch request, hold the Wishbone cycle until termination, pulse ready once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_wb_adr <= '0;
      r_wb_dat <= '0;
      r_wb_sel <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_s_valid) begin
            r_addr   <= mem_s_addr;
            r_wb_adr <= mem_s_addr[ADDR_WIDTH+1:2];
            r_wb_dat <= mem_s_wdata;
            r_we     <= |mem_s_wstrb;
            r_wb_sel <= (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
            r_cyc    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= BUS;
          end
        end
        BUS: begin
          if (w_fail) begin
            r_rdata <= ERR_DATA;
            r_cyc   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= RESP;
          end else if (wb.wb_ack_i) begin
            r_rdata <= r_we ? 32'h0 : wb.wb_dat_i;
            r_cyc   <= 1'b0;
            r_ready <= 1'b1;
            r_state <= RESP;
          end else if (WATCHDOG_ON) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_cyc   <= 1'b0;
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Error capture: first failing address is kept until cleared; a clear beats a same-cycle error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else if (w_bus_fail) begin
      r_err_sticky <= 1'b1;
      if (!r_err_sticky) begin
        r_err_addr <= r_addr;
      end
    end
  end

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// tb/tb_picomem_wb_bridge.sv - directed self-checking bench for picomem_wb_bridge
module tb_picomem_wb_bridge;

  localparam int AW = 28;
  localparam int TO = 8;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_s_valid;
  logic        mem_s_ready;
  logic [31:0] mem_s_addr;
  logic [31:0] mem_s_wdata;
  logic [3:0]  mem_s_wstrb;
  logic [31:0] mem_s_rdata;
  logic        err_sticky;
  logic [31:0] err_addr;
  logic        err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] sb_q[$];
  logic        m_sticky;
  logic [31:0] m_addr;

  always #5 clk = ~clk;

  picomem_wb_bridge_if #(.ADDR_WIDTH(AW)) bus();

  picomem_wb_bridge #(
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA(ERRW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_s_valid(mem_s_valid),
    .mem_s_ready(mem_s_ready),
    .mem_s_addr(mem_s_addr),
    .mem_s_wdata(mem_s_wdata),
    .mem_s_wstrb(mem_s_wstrb),
    .mem_s_rdata(mem_s_rdata),
    .wb(bus),
    .err_sticky(err_sticky),
    .err_addr(err_addr),
    .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cyc"},    {31'h0, bus.wb_cyc_o}, 32'h0);
    check({tag, ".stb"},    {31'h0, bus.wb_stb_o}, 32'h0);
    check({tag, ".we"},     {31'h0, bus.wb_we_o}, 32'h0);
    check({tag, ".adr"},    {4'h0, bus.wb_adr_o}, 32'h0);
    check({tag, ".dat_o"},  bus.wb_dat_o, 32'h0);
    check({tag, ".sel"},    {28'h0, bus.wb_sel_o}, 32'h0);
    check({tag, ".ready"},  {31'h0, mem_s_ready}, 32'h0);
    check({tag, ".rdata"},  mem_s_rdata, 32'h0);
    check({tag, ".sticky"}, {31'h0, err_sticky}, 32'h0);
    check({tag, ".eaddr"},  err_addr, 32'h0);
  endtask

  // Called on a negedge in an IDLE cycle; returns on the negedge of the IDLE cycle after ready.
  // mode: 0 = slave acks, 1 = slave errs, 2 = slave silent (watchdog)
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int waits, input int mode,
                         input logic [31:0] slave_data);
    logic [31:0] exp_rd;
    logic [31:0] got;
    int          exp_lat;
    int          cyc_cnt;
    int          lat;
    bit          done;
    exp_rd  = (mode != 0) ? ERRW : ((wstrb == 4'h0) ? slave_data : 32'h0);
    exp_lat = (mode == 2) ? TO + 1 : waits + 2;
    sb_q.push_back(exp_rd);
    mem_s_valid = 1'b1;
    mem_s_addr  = addr;
    mem_s_wdata = wdata;
    mem_s_wstrb = wstrb;
    done    = 1'b0;
    cyc_cnt = 0;
    lat     = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      bus.wb_dat_i = 32'h5A5A_0F0F;
      if (k == 1) begin
        check({tag, ".cyc1"}, {31'h0, bus.wb_cyc_o}, 32'h1);
        check({tag, ".stb1"}, {31'h0, bus.wb_stb_o}, 32'h1);
        check({tag, ".we"},   {31'h0, bus.wb_we_o}, {31'h0, |wstrb});
        check({tag, ".adr"},  {4'h0, bus.wb_adr_o}, {4'h0, addr[29:2]});
        check({tag, ".sel"},  {28'h0, bus.wb_sel_o}, {28'h0, (wstrb == 4'h0) ? 4'hF : wstrb});
        if (wstrb != 4'h0) check({tag, ".dat_o"}, bus.wb_dat_o, wdata);
      end
      if (mem_s_ready) begin
        done = 1'b1;
        lat  = k;
        mem_s_valid = 1'b0;
        got = sb_q.pop_front();
        check({tag, ".rdata"},   mem_s_rdata, got);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".cyc_off"}, {31'h0, bus.wb_cyc_o}, 32'h0);
        check({tag, ".cyc_len"}, cyc_cnt, exp_lat - 1);
        if (mode != 0) begin
          if (!m_sticky) m_addr = addr;
          m_sticky = 1'b1;
        end
        check({tag, ".sticky"}, {31'h0, err_sticky}, {31'h0, m_sticky});
        check({tag, ".eaddr"},  err_addr, m_addr);
      end else begin
        if (bus.wb_cyc_o) cyc_cnt++;
        if (mode != 2 && k == waits + 1) begin
          if (mode == 0) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = slave_data;
          end else begin
            bus.wb_err_i = 1'b1;
          end
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.no_ready: observed none within 40 cycles expected ready at %0d", tag, exp_lat);
      mem_s_valid = 1'b0;
      if (sb_q.size() > 0) got = sb_q.pop_front();
    end
    @(negedge clk);
    check({tag, ".pulse_end"}, {31'h0, mem_s_ready}, 32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    mem_s_valid  = 1'b0;
    mem_s_addr   = 32'h0;
    mem_s_wdata  = 32'h0;
    mem_s_wstrb  = 4'h0;
    err_clr      = 1'b0;
    bus.wb_dat_i = 32'h0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    m_sticky     = 1'b0;
    m_addr       = 32'h0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_txn("rd0",  32'hC000_0010, 32'h0,         4'h0,    0, 0, 32'h1234_5678);
    run_txn("wr3",  32'hC000_0020, 32'hAABB_CCDD, 4'b0011, 3, 0, 32'h0);
    run_txn("err1", 32'hC000_0100, 32'h0,         4'h0,    0, 1, 32'h0);
    run_txn("err2", 32'hC000_0200, 32'h1111_2222, 4'hF,    1, 1, 32'h0);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr  = 1'b0;
    m_sticky = 1'b0;
    m_addr   = 32'h0;
    check("clr.sticky", {31'h0, err_sticky}, 32'h0);
    check("clr.eaddr",  err_addr, 32'h0);

    run_txn("tmo",  32'hC000_0300, 32'h0,         4'h0,    0, 2, 32'h0);

    run_txn("b2b_wr", 32'hC000_0400, 32'h0102_0304, 4'b1100, 0, 0, 32'h0);
    run_txn("b2b_rd", 32'hFFFF_FFFF, 32'h0,         4'h0,    0, 0, 32'h8765_4321);

    mem_s_valid = 1'b1;
    mem_s_addr  = 32'hC000_0040;
    mem_s_wstrb = 4'h0;
    @(negedge clk);
    check("rst_mid.cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_s_valid = 1'b0;
    m_sticky = 1'b0;
    m_addr   = 32'h0;
    check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (mem_s_ready) seen++;
      end
      check("rst_mid.no_ready", seen, 0);
    end

    run_txn("post", 32'hC000_0044, 32'h0, 4'h0, 2, 0, 32'hCAFE_F00D);

    check("sb.empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
